// File: rtl/mac_layer_engine_if.sv
// -----------------------------------------------------------------------------
// mac_layer_engine_if
// Bundles the control handshake and the four memory buses of mac_layer_engine.
//
//   Control : start, relu_en, bias_en (to engine); busy, ready (from engine)
//   Data RAM    : data_addr   -> / <- data_rdata   (1-cycle read latency)
//   Weight ROM  : weight_addr -> / <- weight_rdata (1-cycle read latency)
//   Bias ROM    : bias_addr   -> / <- bias_rdata   (1-cycle read latency)
//   Output RAM  : out_addr, out_data, out_wren (write port)
//
// Modports:
//   slave  - the engine itself
//   master - the surrounding pipeline / memories that drive and consume it
// -----------------------------------------------------------------------------
interface mac_layer_engine_if #(
   parameter int W       = 32,
   parameter int DADDR_W = 8,
   parameter int WADDR_W = 14,
   parameter int OADDR_W = 6
);

   logic               start;
   logic               relu_en;
   logic               bias_en;
   logic               busy;
   logic               ready;

   logic [DADDR_W-1:0] data_addr;
   logic [W-1:0]       data_rdata;
   logic [WADDR_W-1:0] weight_addr;
   logic [W-1:0]       weight_rdata;
   logic [OADDR_W-1:0] bias_addr;
   logic [W-1:0]       bias_rdata;

   logic [OADDR_W-1:0] out_addr;
   logic [W-1:0]       out_data;
   logic               out_wren;

   modport slave (
      input  start, relu_en, bias_en,
      input  data_rdata, weight_rdata, bias_rdata,
      output busy, ready,
      output data_addr, weight_addr, bias_addr,
      output out_addr, out_data, out_wren
   );

   modport master (
      output start, relu_en, bias_en,
      output data_rdata, weight_rdata, bias_rdata,
      input  busy, ready,
      input  data_addr, weight_addr, bias_addr,
      input  out_addr, out_data, out_wren
   );

endinterface

// File: rtl/mac_layer_engine.sv
// -----------------------------------------------------------------------------
// mac_layer_engine
// Fully-connected layer: for each of N_OUT neurons computes
//   out[o] = sat_W( relu?( bias[o] + sum_i ((data[i] * weight[o*N_IN+i]) >>> FRAC_BITS) ) )
// streaming one multiply-accumulate per cycle from 1-cycle-latency memories,
// and writes each saturated result to the output RAM.
//
// Ports:
//   Clk   - clock, rising edge
//   Reset - asynchronous, active-high reset
//   bus   - mac_layer_engine_if.slave: start/relu_en/bias_en in, busy/ready out,
//           data/weight/bias read buses, output RAM write port
// -----------------------------------------------------------------------------
module mac_layer_engine #(
   parameter int W         = 32,
   parameter int FRAC_BITS = 16,
   parameter int ACC_W     = 48,
   parameter int N_IN      = 250,
   parameter int N_OUT     = 60,
   parameter int DADDR_W   = (N_IN > 1) ? $clog2(N_IN) : 1,
   parameter int WADDR_W   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
   parameter int OADDR_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input logic               Clk,
   input logic               Reset,
   mac_layer_engine_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIAS,
      S_MAC,
      S_DRAIN,
      S_POST,
      S_WRITE,
      S_DONE
   } state_t;

   // Saturation bounds of a W-bit signed result, expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic [DADDR_W-1:0]      LAST_I  = DADDR_W'(N_IN - 1);
   localparam logic [OADDR_W-1:0]      LAST_O  = OADDR_W'(N_OUT - 1);

   state_t                  state;
   state_t                  state_nxt;

   logic [OADDR_W-1:0]      o_idx;
   logic [DADDR_W-1:0]      data_addr;
   logic [WADDR_W-1:0]      weight_addr;
   logic signed [ACC_W-1:0] acc;
   logic [W-1:0]            out_data;
   logic [OADDR_W-1:0]      out_addr;
   logic                    relu_q;
   logic                    bias_q;

   logic                    out_wren;
   logic                    busy;
   logic                    ready;

   logic signed [2*W-1:0]   prod_full;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] relu_acc;
   logic [W-1:0]            sat_val;

   // Full-precision signed product, rescaled to the Q format (floor rounding),
   // then fitted to the accumulator width.
   always_comb begin
      prod_full = $signed(bus.data_rdata) * $signed(bus.weight_rdata);
      prod      = ACC_W'(prod_full >>> FRAC_BITS);
   end

   always_comb begin
      relu_acc = (relu_q && acc[ACC_W-1]) ? '0 : acc;
      if (relu_acc > SAT_MAX) begin
         sat_val = SAT_MAX[W-1:0];
      end else if (relu_acc < SAT_MIN) begin
         sat_val = SAT_MIN[W-1:0];
      end else begin
         sat_val = relu_acc[W-1:0];
      end
   end

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      // NOTE: default first so every path assigns state_nxt; a path that left it
      // unassigned would make the synthesiser infer a latch.
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_BIAS;
         S_BIAS:  state_nxt = S_MAC;
         S_MAC:   if (data_addr == LAST_I) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_POST;
         S_POST:  state_nxt = S_WRITE;
         S_WRITE: state_nxt = (o_idx == LAST_O) ? S_DONE : S_BIAS;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      out_wren = (state == S_WRITE);
      busy     = (state != S_IDLE);
      ready    = (state == S_DONE);
   end

   // ----------------------------------------------------------------- datapath
   // Addresses are registered: a value loaded during cycle t is on the bus in
   // t+1 and its memory word arrives in t+2. Loading element 0 in BIAS therefore
   // lands it one cycle after the bias word (whose address is o_idx, already
   // stable through BIAS), so MAC cycle 0 takes the bias and MAC cycle k (k>=1)
   // and DRAIN take element k-1. During MAC the data address equals k.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         o_idx       <= '0;
         data_addr   <= '0;
         weight_addr <= '0;
         acc         <= '0;
         out_data    <= '0;
         out_addr    <= '0;
         relu_q      <= 1'b0;
         bias_q      <= 1'b0;
      end else begin
         // NOTE: registered state uses non-blocking assignment so every register
         // samples pre-edge values regardless of statement order.
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  relu_q <= bus.relu_en;
                  bias_q <= bus.bias_en;
                  o_idx  <= '0;
               end
            end
            S_BIAS: begin
               data_addr   <= '0;
               weight_addr <= WADDR_W'(o_idx * N_IN);
            end
            S_MAC: begin
               data_addr   <= data_addr + DADDR_W'(1);
               weight_addr <= weight_addr + WADDR_W'(1);
               if (data_addr == '0) begin
                  acc <= bias_q ? ACC_W'($signed(bus.bias_rdata)) : '0;
               end else begin
                  acc <= acc + prod;
               end
            end
            S_DRAIN: begin
               acc <= acc + prod;
            end
            S_POST: begin
               out_data <= sat_val;
               out_addr <= o_idx;
            end
            S_WRITE: begin
               acc <= '0;
               if (o_idx != LAST_O) begin
                  o_idx <= o_idx + OADDR_W'(1);
               end
            end
            S_DONE: begin
               o_idx <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.data_addr   = data_addr;
   assign bus.weight_addr = weight_addr;
   assign bus.bias_addr   = o_idx;
   assign bus.out_addr    = out_addr;
   assign bus.out_data    = out_data;
   assign bus.out_wren    = out_wren;
   assign bus.busy        = busy;
   assign bus.ready       = ready;

endmodule
